// File: rtl/frac_sad_search.sv
// Fractional-pel SAD search: bilinear int/half-H/half-V/half-HV candidates per row, best-SAD pick per block.
// Optional FRAC_SAD_ALL_EN adds the sad_all port carrying all four final SADs.
module frac_sad_search #(
    parameter int BLK_W = 8,
    parameter int BLK_H = 8,
    parameter int PIX_W = 8,
    localparam int SAD_W = PIX_W + $clog2(BLK_W * BLK_H)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sob,
    input  logic [(BLK_W+1)*PIX_W-1:0] filter_pix,
    input  logic [BLK_W*PIX_W-1:0]     ref_pix,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 best_idx,
    output logic [SAD_W-1:0]           best_sad
`ifdef FRAC_SAD_ALL_EN
    ,
    output logic [4*SAD_W-1:0]         sad_all
`endif
);

    localparam int ROW_W = $clog2(BLK_H + 1);

    typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;

    state_t                     state, state_nxt;
    logic [(BLK_W+1)*PIX_W-1:0] p_row;
    logic [SAD_W-1:0]           acc     [4];
    logic [SAD_W-1:0]           row_sad [4];
    logic [ROW_W-1:0]           row_cnt;
    logic                       rdy_en;
    logic                       accept;
    logic [1:0]                 min_idx;
    logic [SAD_W-1:0]           min_sad;

    function automatic logic [PIX_W-1:0] avg2(input logic [PIX_W-1:0] u, input logic [PIX_W-1:0] v);
        logic [PIX_W+1:0] s;
        s = {2'b00, u} + {2'b00, v} + (PIX_W+2)'(1);
        return s[PIX_W:1];
    endfunction

    function automatic logic [PIX_W-1:0] avg4(input logic [PIX_W-1:0] u, input logic [PIX_W-1:0] v,
                                              input logic [PIX_W-1:0] w, input logic [PIX_W-1:0] z);
        logic [PIX_W+1:0] s;
        s = {2'b00, u} + {2'b00, v} + {2'b00, w} + {2'b00, z} + (PIX_W+2)'(2);
        return s[PIX_W+1:2];
    endfunction

    function automatic logic [PIX_W-1:0] absd(input logic [PIX_W-1:0] u, input logic [PIX_W-1:0] v);
        return (u > v) ? (u - v) : (v - u);
    endfunction

    assign accept = in_valid && in_ready;

    // Per-row SAD of the four candidates; P is row y, filter_pix is row y+1.
    always_comb begin : sad_row
        logic [PIX_W-1:0] a, b, c, d, r;
        a = '0; b = '0; c = '0; d = '0; r = '0;
        for (int unsigned i = 0; i < 4; i++) row_sad[i] = '0;
        for (int unsigned x = 0; x < BLK_W; x++) begin
            a = p_row[x*PIX_W +: PIX_W];
            b = p_row[(x+1)*PIX_W +: PIX_W];
            c = filter_pix[x*PIX_W +: PIX_W];
            d = filter_pix[(x+1)*PIX_W +: PIX_W];
            r = ref_pix[x*PIX_W +: PIX_W];
            row_sad[0] = row_sad[0] + SAD_W'(absd(a, r));
            row_sad[1] = row_sad[1] + SAD_W'(absd(avg2(a, b), r));
            row_sad[2] = row_sad[2] + SAD_W'(absd(avg2(a, c), r));
            row_sad[3] = row_sad[3] + SAD_W'(absd(avg4(a, b, c, d), r));
        end
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        min_idx = 2'd0;
        min_sad = acc[0];
        for (int unsigned i = 1; i < 4; i++) begin
            if (acc[i] < min_sad) begin
                min_idx = 2'(i);
                min_sad = acc[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept && in_sob) state_nxt = RUN;
            RUN:  if (accept && !in_sob && row_cnt == ROW_W'(BLK_H - 1)) state_nxt = CMP;
            CMP:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rdy_en && (state == IDLE || state == RUN);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_en   <= 1'b0;
            p_row    <= '0;
            row_cnt  <= '0;
            best_idx <= '0;
            best_sad <= '0;
            for (int unsigned i = 0; i < 4; i++) acc[i] <= '0;
`ifdef FRAC_SAD_ALL_EN
            sad_all  <= '0;
`endif
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                if (in_sob) begin
                    p_row   <= filter_pix;
                    row_cnt <= '0;
                    for (int unsigned i = 0; i < 4; i++) acc[i] <= '0;
                end else if (state == RUN) begin
                    p_row   <= filter_pix;
                    row_cnt <= row_cnt + ROW_W'(1);
                    for (int unsigned i = 0; i < 4; i++) acc[i] <= acc[i] + row_sad[i];
                end
            end
            if (state == CMP) begin
                best_idx <= min_idx;
                best_sad <= min_sad;
`ifdef FRAC_SAD_ALL_EN
                for (int unsigned i = 0; i < 4; i++) sad_all[i*SAD_W +: SAD_W] <= acc[i];
`endif
            end
        end
    end

endmodule

// File: tb/tb_frac_sad_search.sv
// Bench for frac_sad_search: directed and random blocks against a plain-arithmetic SAD model.
module tb_frac_sad_search;

    localparam int BW = 8;
    localparam int BH = 8;
    localparam int PW = 8;
    localparam int SW = 14;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sob;
    logic [(BW+1)*PW-1:0]    filter_pix;
    logic [BW*PW-1:0]        ref_pix;
    logic                    out_valid;
    logic                    out_ready;
    logic [1:0]              best_idx;
    logic [SW-1:0]           best_sad;
`ifdef FRAC_SAD_ALL_EN
    logic [4*SW-1:0]         sad_all;
`endif

    frac_sad_search #(.BLK_W(BW), .BLK_H(BH), .PIX_W(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sob     (in_sob),
        .filter_pix (filter_pix),
        .ref_pix    (ref_pix),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .best_idx   (best_idx),
        .best_sad   (best_sad)
`ifdef FRAC_SAD_ALL_EN
        ,
        .sad_all    (sad_all)
`endif
    );

    always #5 clk = ~clk;

    int fm [BH+1][BW+1];
    int rm [BH][BW];
    int exp_sad [4];
    int exp_idx;
    int n_pass  = 0;
    int n_total = 0;
    int gap_max = 0;

    // Reference: average candidates by integer division, pick first minimum.
    function automatic void model();
        int a, b, c, d, r;
        int cand [4];
        for (int i = 0; i < 4; i++) exp_sad[i] = 0;
        for (int y = 0; y < BH; y++) begin
            for (int x = 0; x < BW; x++) begin
                a = fm[y][x]; b = fm[y][x+1]; c = fm[y+1][x]; d = fm[y+1][x+1]; r = rm[y][x];
                cand[0] = a;
                cand[1] = (a + b + 1) / 2;
                cand[2] = (a + c + 1) / 2;
                cand[3] = (a + b + c + d + 2) / 4;
                for (int i = 0; i < 4; i++)
                    exp_sad[i] += (cand[i] > r) ? cand[i] - r : r - cand[i];
            end
        end
        exp_idx = 0;
        for (int i = 1; i < 4; i++) if (exp_sad[i] < exp_sad[exp_idx]) exp_idx = i;
    endfunction

    function automatic void fill(int mode);
        for (int y = 0; y <= BH; y++)
            for (int x = 0; x <= BW; x++)
                case (mode)
                    0: fm[y][x] = 100;
                    1: fm[y][x] = 10 * x;
                    2: fm[y][x] = 20 * y;
                    3: fm[y][x] = 255;
                    default: fm[y][x] = int'($urandom_range(0, 255));
                endcase
        for (int y = 0; y < BH; y++)
            for (int x = 0; x < BW; x++)
                case (mode)
                    0: rm[y][x] = 100;
                    1: rm[y][x] = 10 * x + 5;
                    2: rm[y][x] = 20 * y + 10;
                    3: rm[y][x] = 0;
                    default: rm[y][x] = (mode == 5) ? fm[y][x] + int'($urandom_range(0, 1)) * (fm[y][x] < 255 ? 1 : 0)
                                                    : int'($urandom_range(0, 255));
                endcase
    endfunction

    task automatic send_beat(input int y, input bit sob);
        bit rdy, done;
        repeat ($urandom_range(0, gap_max)) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        for (int x = 0; x <= BW; x++) filter_pix[x*PW +: PW] = PW'(fm[y][x]);
        for (int x = 0; x < BW; x++) ref_pix[x*PW +: PW] = (y > 0) ? PW'(rm[y-1][x]) : PW'($urandom);
        in_sob   = sob;
        in_valid = 1'b1;
        done     = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) done = 1'b1;
        end
        in_valid = 1'b0;
        in_sob   = 1'b0;
        if (!done) begin
            n_total++;
            $display("FAIL beat_accept row=%0d: in_ready never high within 20 cycles", y);
        end
    endtask

    task automatic send_block();
        for (int y = 0; y <= BH; y++) send_beat(y, y == 0);
    endtask

    // Called right after the last beat's accepting edge.
    task automatic check_result(input string name, input int hold);
        model();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL %s cmp_cycle: out_valid=%0b required 0", name, out_valid);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL %s latency: out_valid=%0b required 1", name, out_valid);
        else n_pass++;
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin @(posedge clk); #1; end
            n_total++;
            if (best_idx !== 2'(exp_idx) || best_sad !== SW'(exp_sad[exp_idx]) || out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL %s result[%0d]: idx=%0d sad=%0d ov=%0b ir=%0b required idx=%0d sad=%0d ov=1 ir=0",
                         name, h, best_idx, best_sad, out_valid, in_ready, exp_idx, exp_sad[exp_idx]);
            else n_pass++;
`ifdef FRAC_SAD_ALL_EN
            for (int i = 0; i < 4; i++) begin
                n_total++;
                if (sad_all[i*SW +: SW] !== SW'(exp_sad[i]))
                    $display("FAIL %s sad_all[%0d]: got %0d required %0d", name, i, sad_all[i*SW +: SW], exp_sad[i]);
                else n_pass++;
            end
`endif
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL %s release: ov=%0b ir=%0b required ov=0 ir=1", name, out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        #12;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || best_idx !== 2'd0 || best_sad !== '0)
            $display("FAIL reset_state: ov=%0b ir=%0b idx=%0d sad=%0d required all 0", out_valid, in_ready, best_idx, best_sad);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL reset_release: in_ready=%0b required 0", in_ready);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL ready_rise: in_ready=%0b required 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        string names [4] = '{"uniform", "hramp", "vramp", "worst"};
        for (int m = 0; m < 4; m++) begin
            fill(m);
            send_block();
            check_result(names[m], 0);
        end
    endtask

    task automatic test_back_pressure();
        fill(4);
        send_block();
        check_result("backpressure", 5);
        fill(1);
        send_block();
        check_result("after_bp", 0);
    endtask

    task automatic test_abort();
        fill(4);
        send_beat(0, 1'b1);
        for (int y = 1; y <= 3; y++) send_beat(y, 1'b0);
        fill(1);
        send_block();
        check_result("abort", 0);
    endtask

    task automatic test_reset_mid();
        fill(4);
        send_beat(0, 1'b1);
        for (int y = 1; y <= 4; y++) send_beat(y, 1'b0);
        #2 reset = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || best_idx !== 2'd0 || best_sad !== '0)
            $display("FAIL mid_reset: ov=%0b ir=%0b idx=%0d sad=%0d required all 0", out_valid, in_ready, best_idx, best_sad);
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            n_total++;
            if (out_valid !== 1'b0) $display("FAIL post_reset_ov[%0d]: out_valid=%0b required 0", c, out_valid);
            else n_pass++;
        end
        fill(4);
        send_block();
        check_result("post_reset", 0);
    endtask

    task automatic test_random();
        gap_max = 2;
        for (int n = 0; n < 8; n++) begin
            fill((n % 2 == 0) ? 4 : 5);
            send_block();
            check_result($sformatf("random%0d", n), int'($urandom_range(0, 2)));
        end
        gap_max = 0;
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_sob     = 1'b0;
        out_ready  = 1'b0;
        filter_pix = '0;
        ref_pix    = '0;
        test_reset();
        test_directed();
        test_back_pressure();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
